// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with byte-lane writes, wait states and two-cycle ERROR
// Address phase is captured on accept; the data phase runs through S_WAIT/S_DATA or S_ERR1/S_ERR2.
module ahb_sram_slave #(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
  localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     addr_off;
  logic            accept;
  logic            addr_err;
  logic [3:0]      be;
  logic            unused_hburst;

  // Bursts are not decoded: every beat carries its own address.
  assign unused_hburst = ^HBURST;

  assign addr_off = HADDR - BASE_ADDR;
  assign accept   = HSEL & HREADY & HTRANS[1];

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                          addr_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])           addr_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) addr_err = 1'b1;
    if (HADDR < BASE_ADDR)                     addr_err = 1'b1;
    if (addr_off >= SPAN)                      addr_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // S_IDLE, S_DATA and S_ERR2 all end with HREADYOUT high and may accept.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = addr_off[AW+1:2];
          lane_d  = HADDR[1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (addr_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      3'd0:    be = 4'b0001 << lane_q;
      3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Write commits on the edge that closes S_DATA, so a read accepted on that edge sees it.
  always_ff @(posedge HCLK) begin
    if ((state_q == S_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed table-driven bench for ahb_sram_slave
// Two instances share the bus: WAIT_STATES=0 first, then WAIT_STATES=3.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [2:0]  HBURST = 3'd0;
  logic [31:0] HWDATA = 32'h0;

  logic        hro0, hresp0, hro1, hresp1;
  logic [31:0] hrd0, hrd1;
  logic        use_ws3 = 1'b0;
  logic        hready_act, hresp_act;
  logic [31:0] hrdata_act;

  int tests = 0;
  int fails = 0;

  assign hready_act = use_ws3 ? hro1 : hro0;
  assign hresp_act  = use_ws3 ? hresp1 : hresp0;
  assign hrdata_act = use_ws3 ? hrd1 : hrd0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hro0),
    .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrd0)
  );

  ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hro1),
    .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrd1)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single NONSEQ transfer followed by IDLE; called and returns just after a rising edge.
  task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic resp,
                      output logic wresp, output int waits);
    int guard;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; HBURST = 3'd0;
    guard = 0;
    @(negedge HCLK);
    while (!hready_act && guard < 50) begin guard++; @(negedge HCLK); end
    if (!hready_act) begin
      tests++; fails++;
      $display("FAIL xfer_accept_timeout: addr %h never saw HREADY", addr);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; wresp = 1'b0;
    @(negedge HCLK);
    while (!hready_act && waits < 50) begin
      wresp = wresp | hresp_act;
      waits++;
      @(negedge HCLK);
    end
    rdata = hrdata_act; resp = hresp_act;
    @(posedge HCLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rsp, wrsp;
    int          nw;
    int          guard;

    vecs[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 3'd2, 32'h010, 32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 3'd0, 32'h013, 32'hAA5A5A5A, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hAA223344, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 32'h012, 32'hBEEF1234, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hBEEF3344, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 32'h011, 32'h00006600, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hBEEF6644, 1'b0};
    vecs[9]  = '{1'b1, 3'd1, 32'h010, 32'hFFFFCAFE, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hBEEFCAFE, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 32'h402, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b1, 3'd2, 32'h000, 32'h12345678, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 3'd2, 32'h002, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 3'd2, 32'h002, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 3'd1, 32'h011, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[16] = '{1'b1, 3'd3, 32'h010, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 3'd2, 32'h000, 32'h0,        32'h12345678, 1'b0};
    vecs[18] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hBEEFCAFE, 1'b0};
    vecs[19] = '{1'b1, 3'd2, 32'h3FC, 32'hA5A55A5A, 32'h0,        1'b0};
    vecs[20] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'hA5A55A5A, 1'b0};
    vecs[21] = '{1'b0, 3'd0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[22] = '{1'b0, 3'd0, 32'h3FF, 32'h0,        32'hA5A55A5A, 1'b0};

    @(negedge HCLK);
    check("rst_hready0", 32'(hro0), 32'h1);
    check("rst_hresp0", 32'(hresp0), 32'h0);
    check("rst_hrdata0", hrd0, 32'h0);
    check("rst_hready1", 32'(hro1), 32'h1);
    check("rst_hresp1", 32'(hresp1), 32'h0);
    check("rst_hrdata1", hrd1, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 23; i++) begin
      xfer(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, rsp, wrsp, nw);
      check($sformatf("vec%0d_hrdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hresp", i), 32'(rsp), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_err1_hresp", i), 32'(wrsp), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_wait_cycles", i), 32'(nw), vecs[i].exp_err ? 32'd1 : 32'd0);
    end

    // Pipelined write 0x55 to 0x40 immediately followed by a read of 0x40.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge HCLK);
    check("b2b_addr_ready", 32'(hro0), 32'h1);
    @(posedge HCLK); #1;
    HWRITE = 1'b0; HWDATA = 32'h55;
    @(negedge HCLK);
    check("b2b_wdata_ready", 32'(hro0), 32'h1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    check("b2b_read_ready", 32'(hro0), 32'h1);
    check("b2b_read_hresp", 32'(hresp0), 32'h0);
    check("b2b_read_hrdata", hrd0, 32'h55);

    // BUSY, IDLE, and NONSEQ with HSEL low must not start a transfer.
    for (int k = 0; k < 3; k++) begin
      HSEL   = (k != 2);
      HTRANS = (k == 0) ? 2'b01 : ((k == 1) ? 2'b00 : 2'b10);
      HADDR  = 32'h40; HWRITE = 1'b0; HSIZE = 3'd2;
      @(posedge HCLK);
      @(negedge HCLK);
      check($sformatf("noacc%0d_hready", k), 32'(hro0), 32'h1);
      check($sformatf("noacc%0d_hresp", k), 32'(hresp0), 32'h0);
      check($sformatf("noacc%0d_hrdata", k), hrd0, 32'h0);
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;

    use_ws3 = 1'b1;
    repeat (6) @(posedge HCLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 3'd2, 32'h20 + 32'(4 * i), 32'hC0DE0000 + 32'(i), rd, rsp, wrsp, nw);
      check($sformatf("ws3_wr%0d_waits", i), 32'(nw), 32'd3);
      check($sformatf("ws3_wr%0d_hresp", i), 32'(rsp | wrsp), 32'h0);
    end

    // INCR4 read; next SEQ address is presented only after HREADY high.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'b011;
    guard = 0;
    @(negedge HCLK);
    while (!hready_act && guard < 20) begin guard++; @(negedge HCLK); end
    check("burst_accept_ready", 32'(hready_act), 32'h1);
    @(posedge HCLK); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        HTRANS = 2'b11; HADDR = 32'h20 + 32'(4 * (i + 1));
      end else begin
        HTRANS = 2'b00; HSEL = 1'b0;
      end
      nw = 0;
      @(negedge HCLK);
      while (!hready_act && nw < 20) begin nw++; @(negedge HCLK); end
      check($sformatf("burst%0d_waits", i), 32'(nw), 32'd3);
      check($sformatf("burst%0d_hrdata", i), hrdata_act, 32'hC0DE0000 + 32'(i));
      check($sformatf("burst%0d_hresp", i), 32'(hresp_act), 32'h0);
      @(posedge HCLK); #1;
    end
    HBURST = 3'd0;

    // Reset during the wait states of a write aborts it.
    xfer(1'b1, 3'd2, 32'h80, 32'h0BADF00D, rd, rsp, wrsp, nw);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h80; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge HCLK);
    check("rstw_accept_ready", 32'(hro1), 32'h1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK);
    check("rstw_in_wait", 32'(hro1), 32'h0);
    #1 HRESETn = 1'b0;
    #1;
    check("rstw_hready", 32'(hro1), 32'h1);
    check("rstw_hresp", 32'(hresp1), 32'h0);
    check("rstw_hrdata", hrd1, 32'h0);
    repeat (5) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b0, 3'd2, 32'h80, 32'h0, rd, rsp, wrsp, nw);
    check("rstw_readback", rd, 32'h0BADF00D);
    check("rstw_read_waits", 32'(nw), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite memory slave directly downstream of the team's AHB master; consumes its HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA and returns HRDATA/HREADY/HRESP.
- Word-organised SRAM model with byte-lane writes, programmable wait states and a two-cycle ERROR response for bad accesses.
- Pipelined address/data phases: the next address phase is accepted in the final cycle of the current data phase.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 1 KiB aligned.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY data phase, 0..15.

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select, address-phase qualifier.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word; 3..7 illegal.
- HBURST  in  3  burst type; accepted, not decoded (every beat carries its own HADDR).
- HWDATA  in  32  write data, valid in the write data phase.
- HREADY  in  1  bus-wide ready; tie to HREADYOUT when single slave.
- HREADYOUT  out  1  slave ready / data-phase complete.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (HRESETn low, async): FSM=S_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, captured address-phase registers cleared. Memory contents are not reset.
- Reset mid-transfer aborts the transfer; no memory write occurs.
- Address-phase accept:
  - Condition: HSEL & HREADY & HTRANS[1] at a rising edge.
  - Captured: word index, HADDR[1:0], HSIZE, HWRITE.
  - IDLE/BUSY, or HSEL low, is not accepted; the next cycle is S_IDLE with an OKAY zero-wait response.
- Error check at accept; ERROR on any of:
  - HSIZE > 2.
  - Half-word with HADDR[0]=1.
  - Word with HADDR[1:0] != 0.
  - HADDR < BASE_ADDR.
  - HADDR - BASE_ADDR >= DEPTH*4.
- FSM states:
  - S_IDLE: HREADYOUT=1, HRESP=0.
  - S_WAIT: HREADYOUT=0, HRESP=0. Counter runs from WAIT_STATES-1 down to 0, then goes to S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=0. Final data cycle; a new accept in this cycle goes to S_WAIT, S_DATA, or S_ERR1 as appropriate. No accept goes to S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1. Always followed by S_ERR2; HTRANS is ignored because HREADY is low.
  - S_ERR2: HREADYOUT=1, HRESP=1. Accepts the next address phase like S_DATA, so a master IDLE here is legal.
- Accepted OKAY transfer goes to S_WAIT if WAIT_STATES>0, otherwise directly to S_DATA. Accepted ERROR transfer goes to S_ERR1.
- Write:
  - Memory is updated on the rising edge that ends S_DATA, using HWDATA at that edge.
  - Byte lanes follow little-endian layout:
    - Byte: lane = addr[1:0].
    - Half-word: lanes addr[1]*2 and addr[1]*2+1.
    - Word: all four lanes.
  - Unselected lanes are unchanged.
  - ERROR transfers never write.
- Read:
  - HRDATA = full 32-bit word at the captured index while in S_DATA with a read captured; otherwise HRDATA=0.
  - No lane masking; the master extracts the lanes it needs.
  - Read latency = 1 + WAIT_STATES cycles after the accept edge.
- Read-after-write to the same word in back-to-back beats returns the new data, because the write commits at the same edge the read is accepted.
- Index arithmetic: index = (HADDR - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after the range check.
- Last word, DEPTH*4-4 from BASE_ADDR, is legal. The next byte address is ERROR; there is no wrap-around.

Test Plan:
- Reset, WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 -> read data phase has HREADYOUT=1, HRESP=0, HRDATA=0xDEADBEEF; during reset all outputs are 1/0/0.
- Byte write 0xAA to 0x13 over existing word 0x11223344 at 0x10 -> readback 0xAA223344. Half write 0xBEEF (HWDATA=0xBEEF0000) to 0x12 -> readback 0xBEEF3344.
- WAIT_STATES=3: 4-beat INCR4 read at 0x20..0x2C -> each beat shows exactly 3 cycles HREADYOUT=0 then 1 with the correct word; the master's SEQ addresses advance only on HREADY high.
- Word read at 0x402 (DEPTH=256) -> one cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. Same response for HSIZE=2 at 0x02; no memory word changes.
- Back-to-back write 0x55 to 0x40 then read 0x40 with WAIT_STATES=0 -> read returns 0x55 with no stall. BUSY/IDLE beats between transfers -> HREADYOUT=1, HRESP=0.
- Assert HRESETn low during S_WAIT of a write to 0x80 -> outputs reset immediately; a later read of 0x80 returns the pre-write value.
